// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: requester ids and the pending-read tag.
package dmem_arb_pkg;

    typedef enum logic {
        ID_P = 1'b0,
        ID_A = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    valid;
        req_id_e id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic    i_req0,
    input  logic    i_req1,
    input  req_id_e i_last,
    output logic    o_gnt0,
    output logic    o_gnt1
);

    logic w_last_a;

    assign w_last_a = (i_last == ID_A);
    assign o_gnt0   = i_req0 & (~i_req1 | w_last_a);
    assign o_gnt1   = i_req1 & (~i_req0 | ~w_last_a);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous dmem between the processor (P) and an
// auxiliary master (A): round-robin with bounded locked bursts, 1-cycle read return.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p_req,
    input  logic              p_lock,
    input  logic              p_wren,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              a_req,
    input  logic              a_lock,
    input  logic              a_wren,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    req_id_e           r_last;
    logic              r_owner_valid;
    req_id_e           r_owner;
    logic [CNT_W-1:0]  r_burst_cnt;
    rd_tag_t           r_rd_pend;
    logic [ADDR_W-1:0] r_addr_hold;
    logic [DATA_W-1:0] r_wdata_hold;
    logic [DATA_W-1:0] r_p_rdata;
    logic [DATA_W-1:0] r_a_rdata;

    logic              w_rr_p;
    logic              w_rr_a;
    logic              w_locked;
    logic              w_at_limit;
    logic              w_owner_req;
    logic              w_gnt_p;
    logic              w_gnt_a;
    logic              w_gnt_any;
    req_id_e           w_gnt_id;
    logic              w_gnt_lock;
    logic              w_gnt_wren;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_p_rvalid;
    logic              w_a_rvalid;

    rr_arb2 u_rr (
        .i_req0 (p_req),
        .i_req1 (a_req),
        .i_last (r_last),
        .o_gnt0 (w_rr_p),
        .o_gnt1 (w_rr_a)
    );

    assign w_locked    = r_owner_valid && (r_burst_cnt < MAX_CNT);
    assign w_at_limit  = r_owner_valid && (r_burst_cnt >= MAX_CNT);
    assign w_owner_req = (r_owner == ID_P) ? p_req : a_req;

    always_comb begin
        w_gnt_p = 1'b0;
        w_gnt_a = 1'b0;
        if (!reset) begin
            if (w_locked && w_owner_req) begin
                w_gnt_p = (r_owner == ID_P);
                w_gnt_a = (r_owner == ID_A);
            end else if (w_at_limit && p_req && a_req) begin
                // Exhausted burst: the lock is ignored and the other side wins the tie.
                w_gnt_p = (r_owner == ID_A);
                w_gnt_a = (r_owner == ID_P);
            end else begin
                w_gnt_p = w_rr_p;
                w_gnt_a = w_rr_a;
            end
        end
    end

    assign w_gnt_any   = w_gnt_p | w_gnt_a;
    assign w_gnt_id    = w_gnt_a ? ID_A : ID_P;
    assign w_gnt_lock  = w_gnt_a ? a_lock  : p_lock;
    assign w_gnt_wren  = w_gnt_a ? a_wren  : p_wren;
    assign w_gnt_addr  = w_gnt_a ? a_addr  : p_addr;
    assign w_gnt_wdata = w_gnt_a ? a_wdata : p_wdata;

    assign p_gnt     = w_gnt_p;
    assign a_gnt     = w_gnt_a;
    assign mem_wren  = w_gnt_any & w_gnt_wren;
    assign mem_addr  = reset ? '0 : (w_gnt_any ? w_gnt_addr  : r_addr_hold);
    assign mem_wdata = reset ? '0 : (w_gnt_any ? w_gnt_wdata : r_wdata_hold);

    assign w_p_rvalid = !reset && r_rd_pend.valid && (r_rd_pend.id == ID_P);
    assign w_a_rvalid = !reset && r_rd_pend.valid && (r_rd_pend.id == ID_A);
    assign p_rvalid   = w_p_rvalid;
    assign a_rvalid   = w_a_rvalid;
    assign p_rdata    = w_p_rvalid ? mem_q : r_p_rdata;
    assign a_rdata    = w_a_rvalid ? mem_q : r_a_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_last        <= ID_A;
            r_owner_valid <= 1'b0;
            r_owner       <= ID_P;
            r_burst_cnt   <= '0;
            r_rd_pend     <= '0;
            r_addr_hold   <= '0;
            r_wdata_hold  <= '0;
            r_p_rdata     <= '0;
            r_a_rdata     <= '0;
        end else begin
            if (w_gnt_any) begin
                r_last       <= w_gnt_id;
                r_addr_hold  <= w_gnt_addr;
                r_wdata_hold <= w_gnt_wdata;
            end

            if (w_gnt_any && w_gnt_lock && !w_at_limit) begin
                r_owner_valid <= 1'b1;
                r_owner       <= w_gnt_id;
                r_burst_cnt   <= (r_owner_valid && r_owner == w_gnt_id)
                                 ? r_burst_cnt + CNT_W'(1) : CNT_W'(1);
            end else begin
                r_owner_valid <= 1'b0;
                r_burst_cnt   <= '0;
            end

            r_rd_pend.valid <= w_gnt_any && !w_gnt_wren;
            r_rd_pend.id    <= w_gnt_id;

            if (w_p_rvalid) r_p_rdata <= mem_q;
            if (w_a_rvalid) r_a_rdata <= mem_q;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clock;
    logic              reset;
    logic              p_req, p_lock, p_wren;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_gnt, p_rvalid;
    logic [DATA_W-1:0] p_rdata;
    logic              a_req, a_lock, a_wren;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_gnt, a_rvalid;
    logic [DATA_W-1:0] a_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    dmem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .p_req     (p_req),
        .p_lock    (p_lock),
        .p_wren    (p_wren),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_gnt     (p_gnt),
        .p_rvalid  (p_rvalid),
        .p_rdata   (p_rdata),
        .a_req     (a_req),
        .a_lock    (a_lock),
        .a_wren    (a_wren),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wren  (mem_wren),
        .mem_q     (mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_val(input int unsigned i);
        if (i == 1) return 32'h0000_0011;
        if (i == 2) return 32'h0000_0022;
        return 32'hA500_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Synchronous single-port dmem instance
    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_init;
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
        end else if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_q <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [DATA_W-1:0] shadow [DEPTH];
    int                m_last, m_holder, m_streak;
    logic [ADDR_W-1:0] m_hold_addr;
    logic [DATA_W-1:0] m_hold_wdata, m_p_hold, m_a_hold, m_pend_data;
    logic              m_pend_valid;
    int                m_pend_id;
    logic              obs_p, obs_a;

    task automatic step();
        int                win;
        logic              lk, wr, exp_prv, exp_arv;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] wd;
        @(negedge clock);
        win = -1;
        if (!reset) begin
            if (m_holder >= 0 && m_streak < MAX_BURST && (m_holder == 0 ? p_req : a_req))
                win = m_holder;
            else if (p_req && a_req)
                win = (m_holder >= 0 && m_streak >= MAX_BURST) ? 1 - m_holder : 1 - m_last;
            else if (p_req)
                win = 0;
            else if (a_req)
                win = 1;
        end
        lk = (win == 1) ? a_lock  : p_lock;
        wr = (win == 1) ? a_wren  : p_wren;
        ad = (win == 1) ? a_addr  : p_addr;
        wd = (win == 1) ? a_wdata : p_wdata;

        obs_p = p_gnt;
        obs_a = a_gnt;
        check("p_gnt", p_gnt, win == 0);
        check("a_gnt", a_gnt, win == 1);
        check("mem_wren", mem_wren, win >= 0 && wr);
        check("mem_addr", mem_addr, reset ? '0 : (win >= 0 ? ad : m_hold_addr));
        check("mem_wdata", mem_wdata, reset ? '0 : (win >= 0 ? wd : m_hold_wdata));

        exp_prv = !reset && m_pend_valid && m_pend_id == 0;
        exp_arv = !reset && m_pend_valid && m_pend_id == 1;
        check("p_rvalid", p_rvalid, exp_prv);
        check("a_rvalid", a_rvalid, exp_arv);
        check("rvalid_excl", p_rvalid & a_rvalid, 0);
        if (!reset) begin
            check("p_rdata", p_rdata, exp_prv ? m_pend_data : m_p_hold);
            check("a_rdata", a_rdata, exp_arv ? m_pend_data : m_a_hold);
        end

        if (reset) begin
            m_last = 1; m_holder = -1; m_streak = 0; m_pend_valid = 1'b0;
            m_p_hold = '0; m_a_hold = '0; m_hold_addr = '0; m_hold_wdata = '0;
        end else begin
            if (exp_prv) m_p_hold = m_pend_data;
            if (exp_arv) m_a_hold = m_pend_data;
            m_pend_valid = 1'b0;
            if (win >= 0) begin
                m_last = win;
                m_hold_addr = ad;
                m_hold_wdata = wd;
                if (!wr) begin
                    m_pend_valid = 1'b1;
                    m_pend_id    = win;
                    m_pend_data  = shadow[ad];
                end else begin
                    shadow[ad] = wd;
                end
                if (lk && m_streak < MAX_BURST) begin
                    m_streak = (m_holder == win) ? m_streak + 1 : 1;
                    m_holder = win;
                end else begin
                    m_holder = -1;
                    m_streak = 0;
                end
            end else begin
                m_holder = -1;
                m_streak = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic drive_p(input logic rq, input logic lk, input logic wr,
                           input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
        p_req = rq; p_lock = lk; p_wren = wr; p_addr = ad; p_wdata = wd;
    endtask

    task automatic drive_a(input logic rq, input logic lk, input logic wr,
                           input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] wd);
        a_req = rq; a_lock = lk; a_wren = wr; a_addr = ad; a_wdata = wd;
    endtask

    // Counts A grants up to the first P grant over a bounded window
    task automatic count_a_run(input int budget, output int run);
        bit seen_p;
        run = 0;
        seen_p = 0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!seen_p) begin
                if (obs_p) seen_p = 1;
                else if (obs_a) run++;
            end
        end
    endtask

    initial begin
        int run;
        for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
        m_last = 1; m_holder = -1; m_streak = 0; m_pend_valid = 1'b0; m_pend_id = 0;
        m_p_hold = '0; m_a_hold = '0; m_hold_addr = '0; m_hold_wdata = '0; m_pend_data = '0;

        // Reset held with both requesting, then strict alternation starting at P
        reset = 1'b1;
        mem_init = 1'b1;
        drive_p(1, 0, 0, 12'h003, '0);
        drive_a(1, 0, 0, 12'h004, '0);
        #1;
        step();
        mem_init = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check("t1_first_p", obs_p, 1);
        step();
        check("t1_second_a", obs_a, 1);
        for (int i = 0; i < 4; i++) step();

        // P write then read-back of the same address
        drive_a(0, 0, 0, '0, '0);
        drive_p(1, 0, 1, 12'h010, 32'hDEADBEEF);
        step();
        drive_p(1, 0, 0, 12'h010, '0);
        step();
        drive_p(0, 0, 0, '0, '0);
        step();
        check("t2_readback", p_rdata, 32'hDEADBEEF);

        // A locked burst with P contending: exactly MAX_BURST A grants
        drive_p(1, 0, 0, 12'h020, '0);
        drive_a(1, 1, 0, 12'h030, '0);
        count_a_run(12, run);
        check("t3_burst_len", run, MAX_BURST);

        // Alternating reads from the two ports
        drive_p(1, 0, 0, 12'h001, '0);
        drive_a(0, 0, 0, '0, '0);
        step();
        drive_p(0, 0, 0, '0, '0);
        drive_a(1, 0, 0, 12'h002, '0);
        step();
        check("t4_p_data", p_rdata, 32'h11);
        drive_a(0, 0, 0, '0, '0);
        step();
        check("t4_a_data", a_rdata, 32'h22);

        // Reset right after an A read grant
        drive_a(1, 1, 0, 12'h005, '0);
        step();
        reset = 1'b1;
        drive_p(1, 0, 0, 12'h006, '0);
        drive_a(1, 1, 0, 12'h007, '0);
        step();
        reset = 1'b0;
        step();
        check("t5_p_first", obs_p, 1);
        step();

        // A drops req for a cycle mid-lock; its burst count restarts
        drive_p(0, 0, 0, '0, '0);
        drive_a(1, 1, 1, 12'h040, 32'h1234_5678);
        for (int i = 0; i < 3; i++) step();
        drive_p(1, 0, 0, 12'h040, '0);
        drive_a(0, 1, 0, '0, '0);
        step();
        check("t6_p_gap", obs_p, 1);
        drive_a(1, 1, 0, 12'h041, '0);
        count_a_run(12, run);
        check("t6_restart_len", run, MAX_BURST);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            drive_p($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                    ADDR_W'($urandom_range(0, 15)), $urandom);
            drive_a($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                    ADDR_W'($urandom_range(0, 15)), $urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: the processor (port P) and an auxiliary loader/debug master (port A).
- Sits between the processor's dmem interface and the dmem instance.
- Performs one access per cycle with round-robin arbitration and bounded locked bursts.
- Returns read data with a tagged valid strobe one cycle after the grant.

Parameters:
- ADDR_W, 12, dmem word-address width.
- DATA_W, 32, data width.
- MAX_BURST, 8, maximum consecutive grants to one locked requester (≥1).

Ports:
- clock  in  1  single system clock; every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- p_req  in  1  processor access request.
- p_lock  in  1  processor asks to keep the grant next cycle.
- p_wren  in  1  1 = write, 0 = read.
- p_addr  in  ADDR_W  processor address.
- p_wdata  in  DATA_W  processor write data.
- p_gnt  out  1  processor access accepted this cycle.
- p_rvalid  out  1  p_rdata is valid (read granted in the previous cycle).
- p_rdata  out  DATA_W  read data for the processor.
- a_req, a_lock, a_wren, a_addr, a_wdata, a_gnt, a_rvalid, a_rdata: auxiliary port; same widths and meanings as the P port.
- mem_addr  out  ADDR_W  to dmem address.
- mem_wdata  out  DATA_W  to dmem data.
- mem_wren  out  1  to dmem write enable.
- mem_q  in  DATA_W  dmem output, valid the cycle after the address is presented.

Behaviour:
- Grant logic
  - Combinational from the current requests and the registered state.
  - At most one of p_gnt/a_gnt is high; gnt never asserts without its req.
- Memory drive
  - Granted requester's addr/wdata/wren pass combinationally to mem_*.
  - No grant: mem_wren=0; mem_addr/mem_wdata hold the last granted values (no toggling).
- Arbitration state, registered: last (0=P, 1=A), owner_valid, owner, burst_cnt (clog2(MAX_BURST+1) bits).
- States
  - IDLE: owner_valid=0.
    - Only one req → grant it.
    - Both req → grant the one not equal to last.
  - LOCKED: owner_valid=1 and burst_cnt<MAX_BURST.
    - Owner's req high → owner granted regardless of the other req.
    - Owner's req low → lock released this cycle; arbitrate as IDLE.
- Update on each grant
  - last ← granted id.
  - If the granted lock=1: owner_valid←1, owner←id, burst_cnt ← burst_cnt+1 when the same owner continues, else 1.
  - If lock=0 or no grant: owner_valid←0, burst_cnt←0.
- Burst limit: when burst_cnt reaches MAX_BURST, the lock is ignored for one arbitration. Both req → the other requester wins; owner_valid←0 and burst_cnt←0 after that grant. This bounds starvation to MAX_BURST cycles.
- Read return
  - Registered tag rd_pend (valid, id) set when a read (wren=0) is granted.
  - Next cycle: x_rvalid=1 for the tagged id only; x_rdata=mem_q.
  - Untagged port's rdata holds its last value.
  - Writes produce no rvalid.
  - Read latency is exactly 1 cycle after gnt, independent of subsequent grants. Back-to-back reads from alternating ports return in grant order.
- Same-address write then read on consecutive cycles: the read returns the new data (dmem write-first is not required; the one-cycle separation guarantees it).
- Reset, synchronous, any cycle, including mid-burst or with a read pending:
  - last←1, so P wins the first tie.
  - owner_valid←0, burst_cnt←0, rd_pend←0.
  - p_rdata/a_rdata←0.
  - With reset high: all gnt=0, rvalid=0, mem_wren=0, mem_addr=0, mem_wdata=0.
  - An in-flight read's rvalid is suppressed.
- No back-pressure on rvalid; requesters must accept the data.

Decomposition:
- Shared package dmem_arb_pkg: requester id constants (ID_P=0, ID_A=1) and the read-tag struct {valid, id}.
- One natural sub-module: rr_arb2, a two-way round-robin pick from {req0, req1, last}. The lock/burst handling and the read tag stay in dmem_arbiter.

Test Plan:
1. Reset held 3 cycles with p_req=a_req=1 → no gnt, mem_wren=0. After release, cycle 1: p_gnt=1. Cycle 2: a_gnt=1, alternating thereafter.
2. P write addr 0x010 data 0xDEADBEEF, then P read 0x010 next cycle → p_rvalid one cycle after the read gnt, p_rdata=0xDEADBEEF; a_rvalid stays 0.
3. A locks with a_lock=1, a_req=1 continuously, P requesting throughout, MAX_BURST=8 → A granted exactly 8 consecutive cycles, then p_gnt=1 on the 9th.
4. Alternating reads: P reads 0x001 (mem=0x11), A reads 0x002 (mem=0x22) → p_rvalid/0x11, then a_rvalid/0x22 on consecutive cycles, never both high.
5. Reset asserted the cycle after an A read grant → a_rvalid=0 the following cycle, lock cleared, first post-reset tie goes to P.
6. A holds lock and drops a_req for one cycle while P requests → P granted that cycle; A's burst_cnt restarts at 1 on its next locked grant.
